tb_pzcorebus_response_delay: RTL
================================

TB_PZCOREBUS_RESPONSE_DELAY -- requirements
Module: tb_pzcorebus_response_delay

Interface
REQ-001 SHALL have parameter RESPONSE_WIDTH, default 64, bit width of the packed response payload (sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter DELAY, default 100, minimum cycles from accept to presentation; range 0..65535.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port i_resp_valid, input, 1, upstream response valid (from slave BFM sresp_valid).
REQ-007 SHALL have port o_resp_accept, output, 1, upstream accept (to slave BFM mresp_accept).
REQ-008 SHALL have port i_resp, input, RESPONSE_WIDTH, upstream payload.
REQ-009 SHALL have port o_resp_valid, output, 1, downstream response valid.
REQ-010 SHALL have port i_resp_accept, input, 1, downstream accept.
REQ-011 SHALL have port o_resp, output, RESPONSE_WIDTH, downstream payload.
REQ-012 SHALL have port o_count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-013 SHALL push when i_resp_valid && o_resp_accept; pop when o_resp_valid && i_resp_accept.
REQ-014 SHALL drive o_resp_accept = (count < DEPTH) && i_rst_n; no full-bypass, push refused when full even if a pop occurs in the same cycle.
REQ-015 SHALL preserve order; o_resp equals the head entry's payload, unmodified.
REQ-016 SHALL keep a free-running 16-bit cycle counter (wraps 65535->0) and store its value as each entry's timestamp at push.
REQ-017 SHALL keep one sticky "matured" bit per entry: cleared at push, set when (counter - timestamp) mod 2^16 >= DELAY and >= 1; once set stays set until pop, so ages beyond 65535 cycles do not un-mature.
REQ-018 SHALL drive o_resp_valid = (count != 0) && head matured (combinationally from the head entry's age or matured bit).
REQ-019 SHALL therefore present an entry pushed at cycle t no earlier than cycle t + max(1, DELAY); DELAY=0 gives one-cycle latency.
REQ-020 SHALL, once o_resp_valid is high, hold it and o_resp stable until pop.
REQ-021 SHALL allow push and pop in the same cycle when 0 < count < DEPTH; count unchanged.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; o_count updates one cycle after the push/pop edge (registered).
REQ-023 SHALL ignore i_resp and i_resp_accept when the corresponding handshake is not enabled.
REQ-024 SHALL allow successive entries behind a matured head to be already matured, giving back-to-back output at one per cycle.

Reset
REQ-025 SHALL, while i_rst_n is low at a rising edge, clear pointers, count, cycle counter and all matured bits.
REQ-026 SHALL hold o_resp_valid=0, o_resp_accept=0, o_count=0 while i_rst_n is low; o_resp_accept=1 from first cycle after release.
REQ-027 SHALL discard all stored entries on reset asserted mid-operation; no response is presented afterward unless newly pushed.
REQ-028 o_resp content while o_resp_valid=0 is don't-care.

Verification
REQ-029 DELAY=4: push A at cycle 10 with i_resp_accept=1 -> o_resp_valid rises at cycle 14 with o_resp=A, popped same cycle, o_count 1->0.
REQ-030 DELAY=0: push every cycle, downstream always accepts -> each payload appears exactly 1 cycle after push, throughput 1/cycle, o_count stays 1.
REQ-031 DEPTH=4, DELAY=2, i_resp_accept=0: push 5 -> 4 accepted, o_resp_accept=0 at count 4; raise accept -> 4 outputs in order on consecutive cycles, 5th push accepted the cycle after first pop.
REQ-032 DELAY=10, hold i_resp_accept=0 for 70000 cycles after push -> o_resp_valid stays 1 throughout (no counter-wrap drop), payload stable.
REQ-033 Push 3 entries, assert i_rst_n=0 for 1 cycle before any matures -> o_count=0, o_resp_valid never rises, o_resp_accept=0 during reset, 1 after.
REQ-034 Full with head matured, simultaneous valid and accept -> pop occurs, push refused that cycle, count DEPTH-1, then accepted next cycle.

Source files
------------

// File: rtl/tb_pzcorebus_response_delay.sv
// Response delay FIFO: holds each response until it has aged at least
// max(1, DELAY) cycles since acceptance, then presents it in order.
module tb_pzcorebus_response_delay #(
  parameter int RESPONSE_WIDTH = 64,
  parameter int DEPTH          = 16,
  parameter int DELAY          = 100
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_resp_valid,
  output logic                      o_resp_accept,
  input  logic [RESPONSE_WIDTH-1:0] i_resp,
  output logic                      o_resp_valid,
  input  logic                      i_resp_accept,
  output logic [RESPONSE_WIDTH-1:0] o_resp,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DLY_EFF = (DELAY == 0) ? 16'd1 : 16'(DELAY);

  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [15:0]               cyc_q, cyc_d;
  logic [RESPONSE_WIDTH-1:0] data_q [DEPTH];
  logic [RESPONSE_WIDTH-1:0] data_d [DEPTH];
  logic [15:0]               ts_q [DEPTH];
  logic [15:0]               ts_d [DEPTH];
  logic [DEPTH-1:0]          mat_q, mat_d;
  logic [DEPTH-1:0]          aged;
  logic                      push, pop;

  // Age is modular; the sticky matured bit covers entries older than 2^16.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    logic [15:0] age;
    assign age     = cyc_q - ts_q[i];
    assign aged[i] = (age >= DLY_EFF);
  end

  assign o_resp_accept = i_rst_n && (count_q < CW'(DEPTH));
  assign o_resp_valid  = i_rst_n && (count_q != '0) && (mat_q[rd_ptr_q] || aged[rd_ptr_q]);
  assign o_resp        = data_q[rd_ptr_q];
  assign o_count       = count_q;

  assign push = i_resp_valid && o_resp_accept;
  assign pop  = o_resp_valid && i_resp_accept;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    cyc_d    = cyc_q + 16'd1;
    data_d   = data_q;
    ts_d     = ts_q;
    mat_d    = mat_q | aged;
    if (push) begin
      data_d[wr_ptr_q] = i_resp;
      ts_d[wr_ptr_q]   = cyc_q;
      mat_d[wr_ptr_q]  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      mat_q    <= '0;
      for (int i = 0; i < DEPTH; i++) ts_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
      mat_q    <= mat_d;
      ts_q     <= ts_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
  end

endmodule
